// File: rtl/tl_ul_mem_responder.sv
// tl_ul_mem_responder
//
// TileLink-UL responder that terminates a Channel A request stream and
// answers on Channel D. It backs a word-addressed SRAM with byte-lane
// writes and a programmable access latency, and serves one transaction
// at a time.
//
// Requests that are malformed or fall outside the decoded window complete
// with d_error=1 and zero data, and they leave the array untouched.
//
// Ports
//   clk, reset            clock and asynchronous active-high reset
//   a_valid / a_ready     Channel A handshake (a_ready high only while idle)
//   a_opcode, a_param     request opcode (PutFull=0, PutPartial=1, Get=4);
//                         a_param is ignored
//   a_size, a_source      log2 transfer bytes and requester ID
//   a_address             request byte address
//   a_mask, a_data        write byte lanes and write data
//   d_valid / d_ready     Channel D handshake
//   d_opcode, d_param     AccessAck=0 or AccessAckData=1; d_param is always 0
//   d_size, d_source      echoes of the captured request
//   d_sink                constant SINK_ID
//   d_data, d_error       read data and the denied flag

module tl_ul_mem_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int SRC_WIDTH    = 2,
  parameter int SINK_WIDTH   = 1,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int DEPTH        = 256,
  parameter int LATENCY      = 1,
  parameter logic [SINK_WIDTH-1:0] SINK_ID = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_WIDTH-1:0]   d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
);

  localparam int LANE_BITS = $clog2(MASK_WIDTH);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(LATENCY + 1);

  localparam logic [OPCODE_WIDTH-1:0] PUT_FULL    = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] PUT_PARTIAL = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] GET         = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] ACK         = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] ACK_DATA    = OPCODE_WIDTH'(1);

  // The window bounds carry one extra bit so that a window ending exactly
  // at the top of the address space does not wrap.
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(DEPTH * MASK_WIDTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [OPCODE_WIDTH-1:0] reqOpcode_q;
  logic [SIZE_WIDTH-1:0]   reqSize_q;
  logic [SRC_WIDTH-1:0]    reqSource_q;
  logic [IDX_W-1:0]        reqIdx_q;
  logic [MASK_WIDTH-1:0]   reqMask_q;
  logic [DATA_WIDTH-1:0]   reqData_q;
  logic                    reqErr_q;

  logic [OPCODE_WIDTH-1:0] rspOpcode_q;
  logic [SIZE_WIDTH-1:0]   rspSize_q;
  logic [SRC_WIDTH-1:0]    rspSource_q;
  logic [DATA_WIDTH-1:0]   rspData_q;
  logic                    rspError_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic                    accessFire;
  logic                    memWrite;
  logic                    reqIsGet;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [ADDR_WIDTH-1:0]   alignMask;
  logic [MASK_WIDTH-1:0]   impliedMask;
  int                      laneLo;
  int                      laneCount;
  logic                    opBad, sizeBad, alignBad, rangeBad, maskBad, reqErr;
  logic                    unusedBits;

  assign accept     = a_valid && a_ready;
  assign accessFire = (state_q == ACCESS) && (cnt_q == '0);
  assign reqIsGet   = (reqOpcode_q == GET);
  assign memWrite   = accessFire && !reqErr_q && !reqIsGet;

  // The word index comes from the offset into the window. The byte-lane
  // bits and the bits above the array depth are dropped on purpose.
  assign offset     = a_address - BASE_ADDR;
  assign unusedBits = ^{a_param, offset[LANE_BITS-1:0], offset[ADDR_WIDTH-1:LANE_BITS+IDX_W]};

  // The lanes a PutFullData must enable are the 2^size contiguous bytes
  // that start at the byte offset of the address within the word.
  always_comb begin
    laneLo      = int'(a_address[LANE_BITS-1:0]);
    laneCount   = 1 << a_size;
    impliedMask = '0;
    for (int k = 0; k < MASK_WIDTH; k++) begin
      if (k >= laneLo && k < laneLo + laneCount) impliedMask[k] = 1'b1;
    end
  end

  // Request checks are evaluated on the live Channel A fields and captured
  // together with the request at accept time.
  always_comb begin
    alignMask = (ADDR_WIDTH'(1) << a_size) - ADDR_WIDTH'(1);
    opBad     = !(a_opcode == PUT_FULL || a_opcode == PUT_PARTIAL || a_opcode == GET);
    sizeBad   = a_size > SIZE_WIDTH'(LANE_BITS);
    alignBad  = (a_address & alignMask) != '0;
    rangeBad  = ({1'b0, a_address} < WIN_LO) || ({1'b0, a_address} >= WIN_HI);
    maskBad   = (a_opcode == PUT_FULL) && (a_mask != impliedMask);
    reqErr    = opBad || sizeBad || alignBad || rangeBad || maskBad;
  end

  // State register. An asynchronous reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. While the block is not idle, a_valid is ignored.
  // While no response is pending, d_ready is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        if (d_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The handshake flags are decoded directly from the state,
  // so reset drops d_valid at once. The response fields come from registers
  // that hold steady for the whole RESP phase.
  always_comb begin
    a_ready  = (state_q == IDLE);
    d_valid  = (state_q == RESP);
    d_opcode = rspOpcode_q;
    d_param  = '0;
    d_size   = rspSize_q;
    d_source = rspSource_q;
    d_sink   = SINK_ID;
    d_data   = rspData_q;
    d_error  = rspError_q;
  end

  // Request capture on the Channel A handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqOpcode_q <= '0;
      reqSize_q   <= '0;
      reqSource_q <= '0;
      reqIdx_q    <= '0;
      reqMask_q   <= '0;
      reqData_q   <= '0;
      reqErr_q    <= 1'b0;
    end else if (accept) begin
      reqOpcode_q <= a_opcode;
      reqSize_q   <= a_size;
      reqSource_q <= a_source;
      reqIdx_q    <= offset[LANE_BITS +: IDX_W];
      reqMask_q   <= a_mask;
      reqData_q   <= a_data;
      reqErr_q    <= reqErr;
    end
  end

  // Response registers load on the final access cycle. A Get that passes
  // all checks returns the whole stored word whatever its mask is.
  // Everything else returns zero data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rspOpcode_q <= '0;
      rspSize_q   <= '0;
      rspSource_q <= '0;
      rspData_q   <= '0;
      rspError_q  <= 1'b0;
    end else if (accessFire) begin
      rspOpcode_q <= reqIsGet ? ACK_DATA : ACK;
      rspSize_q   <= reqSize_q;
      rspSource_q <= reqSource_q;
      rspData_q   <= (reqIsGet && !reqErr_q) ? mem[reqIdx_q] : '0;
      rspError_q  <= reqErr_q;
    end
  end

  // The storage array has no reset, so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      for (int k = 0; k < MASK_WIDTH; k++) begin
        if (reqMask_q[k]) mem[reqIdx_q][8*k +: 8] <= reqData_q[8*k +: 8];
      end
    end
  end

endmodule
